// File: rtl/cam_bt656_timing_decoder_if.sv
// BT.656 byte stream in, decoded pixel stream and timing flags out.
// The master side is the byte source; the decoder sits on the slave side.
interface cam_bt656_timing_decoder_if;
    logic [7:0] cam_data;
    logic [7:0] cam_pix_data;
    logic       cam_pix_valid;
    logic       cam_line_valid;
    logic       cam_field_toggle;
    logic       cam_field;
    logic       cam_sync_locked;
    logic       cam_hdr_err;

    modport master (
        output cam_data,
        input  cam_pix_data, cam_pix_valid, cam_line_valid, cam_field_toggle,
        input  cam_field, cam_sync_locked, cam_hdr_err
    );

    modport slave (
        input  cam_data,
        output cam_pix_data, cam_pix_valid, cam_line_valid, cam_field_toggle,
        output cam_field, cam_sync_locked, cam_hdr_err
    );
endinterface

// File: rtl/cam_bt656_timing_decoder.sv
// BT.656 timing decoder: finds FF 00 00 XY headers, tracks lock and field,
// and tags a 4-cycle delayed copy of the byte stream as active video.
module cam_bt656_timing_decoder #(
    parameter bit          CHECK_PROT   = 1'b1,
    parameter int unsigned LINE_TIMEOUT = 2047
) (
    input  logic                      cam_pclk,
    input  logic                      cam_rst,
    cam_bt656_timing_decoder_if.slave bus
);
    typedef enum logic [1:0] {SCAN, FF, Z1, Z2} state_t;

    state_t          state, state_nx;
    logic [7:0]      din;
    logic            is_xy, f, v, h, prot_ok, hdr_ok, hdr_bad, timeout;
    logic [10:0]     cnt, cnt_inc;
    logic            locked, active, field_int, tog_int, hdr_err;
    logic [3:0][7:0] data_pipe;
    logic [3:0]      tag_pipe;
    logic [2:0]      fld_pipe, tog_pipe;

    assign din = bus.cam_data;

    always_ff @(posedge cam_pclk) begin
        if (cam_rst) state <= SCAN;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        is_xy    = 1'b0;
        case (state)
            SCAN: if (din == 8'hFF) state_nx = FF;
            FF: begin
                if (din == 8'h00)      state_nx = Z1;
                else if (din != 8'hFF) state_nx = SCAN;
            end
            Z1: begin
                if (din == 8'h00)      state_nx = Z2;
                else if (din == 8'hFF) state_nx = FF;
                else                   state_nx = SCAN;
            end
            Z2: begin
                is_xy    = 1'b1;
                state_nx = SCAN;
            end
            default: state_nx = SCAN;
        endcase
    end

    assign f       = din[6];
    assign v       = din[5];
    assign h       = din[4];
    assign prot_ok = (din[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
    assign hdr_ok  = is_xy && din[7] && (prot_ok || !CHECK_PROT);
    assign hdr_bad = is_xy && !hdr_ok;
    assign cnt_inc = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    assign timeout = (32'(cnt_inc) >= LINE_TIMEOUT);

    // A valid header wins over a coincident timeout.
    always_ff @(posedge cam_pclk) begin
        if (cam_rst) begin
            cnt       <= '0;
            locked    <= 1'b0;
            active    <= 1'b0;
            field_int <= 1'b0;
            tog_int   <= 1'b0;
            hdr_err   <= 1'b0;
        end else begin
            hdr_err <= hdr_bad;
            cnt     <= hdr_ok ? 11'd0 : cnt_inc;
            if (hdr_ok) begin
                locked <= 1'b1;
                active <= !v && !h;
                if (h) begin
                    field_int <= f;
                    if (locked && (f != field_int)) tog_int <= ~tog_int;
                end
            end else if (hdr_bad || timeout) begin
                locked <= 1'b0;
                active <= 1'b0;
            end
        end
    end

    // On an XY byte the whole tag pipe clears: it holds exactly the three
    // preamble bytes, and the XY itself enters untagged.
    always_ff @(posedge cam_pclk) begin
        if (cam_rst) begin
            data_pipe <= '0;
            tag_pipe  <= '0;
            fld_pipe  <= '0;
            tog_pipe  <= '0;
        end else begin
            data_pipe <= {data_pipe[2:0], din};
            tag_pipe  <= is_xy ? 4'b0000 : {tag_pipe[2:0], active & locked};
            fld_pipe  <= {fld_pipe[1:0], field_int};
            tog_pipe  <= {tog_pipe[1:0], tog_int};
        end
    end

    assign bus.cam_pix_data     = data_pipe[3];
    assign bus.cam_pix_valid    = tag_pipe[3];
    assign bus.cam_line_valid   = tag_pipe[3];
    assign bus.cam_field        = fld_pipe[2];
    assign bus.cam_field_toggle = tog_pipe[2];
    assign bus.cam_sync_locked  = locked;
    assign bus.cam_hdr_err      = hdr_err;
endmodule
